systolic_skew_streamer: RTL and testbench
=========================================

// Module: systolic_skew_streamer
// PURPOSE
//  Parametrised successor to the systolic input-skew stage. Accepts one LENGTH-lane vector per cycle
//  over a valid/ready handshake, delays lane i by i cycles to form the wavefront feeding a LENGTHxLENGTH
//  systolic PE array, then self-drains after the tile's last vector and pulses tile_done.
// PARAMETERS
//  WIDTH     8    bits per lane element
//  LENGTH    5    lane count = systolic array edge (>=1)
//  MAX_ROWS  256  max vectors per tile; sizes row counter ($clog2(MAX_ROWS+1))
// PORTS
//  CLK          in   1             single clock, rising edge
//  ASYNC_RST    in   1             asynchronous, active-high reset
//  SYNC_RST     in   1             synchronous clear, active-high, same effect as ASYNC_RST
//  EN           in   1             global advance enable; 0 freezes all state
//  in_valid     in   1             input vector valid
//  in_last      in   1             qualifies in_valid: final vector of tile
//  in_data      in   WIDTH*LENGTH  packed input vector, lane i = in_data[i*WIDTH +: WIDTH]
//  in_ready     out  1             block accepts vector this cycle
//  out_data     out  WIDTH*LENGTH  skewed wavefront to array edge
//  tile_done    out  1             one-cycle pulse: last element of tile left lane LENGTH-1
//  row_count    out  CW            vectors accepted in current tile
//  overflow     out  1             sticky: MAX_ROWS reached without in_last
// BEHAVIOUR
//  Reset (async or sync): state=IDLE, all lane regs/valids 0, out_data=0, tile_done=0, row_count=0, overflow=0.
//  Lane i = chain of i+1 registers; accepted element at edge k appears on lane i after edge k+i.
//  Accept = in_valid & in_ready at rising edge. Non-accept cycles inject 0 (bubble, valid 0) into every lane.
//  in_ready = EN & (state != DRAIN) & ~SYNC_RST. Combinational, no dependence on in_valid.
//  FSM: IDLE -accept-> STREAM (or DRAIN if in_last); STREAM -accept&in_last-> DRAIN;
//   DRAIN counts LENGTH-1 enabled cycles, then -> IDLE with tile_done=1 for one cycle.
//   LENGTH==1: accept&in_last goes straight to IDLE, tile_done set on that edge.
//  Accept at row_count==MAX_ROWS-1 without in_last: treated as last (enter DRAIN), overflow set (sticky until reset).
//  row_count: +1 per accept, cleared on the edge tile_done is set; saturates at MAX_ROWS.
//  EN=0: no register changes, drain counter holds, tile_done forced 0 that cycle (pulse resumes only on EN edge).
//  New tile may start the cycle after tile_done (IDLE accepts immediately); no back-to-back overlap in DRAIN.
//  Reset mid-tile: pipeline flushed to zero, in-flight elements discarded, no tile_done.
// CONFIGURATION
//  LANE_VALID_EN defined: extra port out_lane_valid [LENGTH-1:0] out; bit i = valid bit travelling with
//   lane i's element (1 for accepted data, 0 for bubbles/drain), reset 0.
//  Not defined: port absent; valid bits still tracked internally for drain/overflow logic only; out_data
//   behaviour identical.
// STRUCTURE
//  Package systolic_pkg: typedef skew_state_e {IDLE, STREAM, DRAIN}; function clog2-based CW helper;
//   shared lane-slice macro-free function lane_get(vec, i).
//  Sub-module skew_delay_line (WIDTH+1 bits, DEPTH param) instantiated per lane via generate, DEPTH=i+1;
//   carries data+valid, EN/SYNC_RST gated. Top holds FSM, counters, handshake.
// TESTING (WIDTH=8, LENGTH=4, MAX_ROWS=8)
//  1 Reset: ASYNC_RST high mid-clock -> out_data=0, tile_done=0, in_ready=0 until EN=1, then in_ready=1.
//  2 Skew: 4 vectors {r,r,r,r}, r=1..4, last on r=4 -> lane0 shows 1,2,3,4 after edges k..k+3; lane3 shows 1
//    after edge k+3, 4 after k+6; tile_done pulses after edge k+6; row_count 4 then 0.
//  3 Bubbles: in_valid low 2 cycles between rows 2 and 3 -> zeros on each lane at matching skewed slots;
//    in_ready stays 1 in STREAM; with LANE_VALID_EN bubble bits 0.
//  4 Stall: EN=0 for 3 cycles during DRAIN -> out_data/drain count frozen, tile_done delayed by exactly 3 cycles.
//  5 Overflow: 8 vectors, no in_last -> 8th accept enters DRAIN, overflow=1, tile_done after 3 more cycles.
//  6 Mid-tile SYNC_RST after 2 rows -> next edge all lanes 0, state IDLE, no tile_done, overflow stays 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic skew streamer.
//  skew_state_e : tile sequencing state (IDLE / STREAM / DRAIN)
//  cw_of        : row counter width able to hold 0..max_rows
//  lane_get     : extract lane i (w bits wide) from a packed lane vector
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skew_state_e;

  // Bounds of the lane helper: lanes up to 64 bits, vectors up to 2048 bits.
  localparam int LANE_MAX = 64;
  localparam int VEC_MAX  = 2048;

  function automatic int cw_of(input int max_rows);
    return $clog2(max_rows + 1);
  endfunction

  function automatic logic [LANE_MAX-1:0] lane_get(input logic [VEC_MAX-1:0] vec,
                                                   input int w, input int i);
    logic [VEC_MAX-1:0]  sh;
    logic [LANE_MAX-1:0] mask;
    sh   = vec >> (i * w);
    mask = {LANE_MAX{1'b1}} >> (LANE_MAX - w);
    return sh[LANE_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth delay line carrying one lane element plus its valid bit.
//  clk, rst      : clock, asynchronous active-high reset
//  sync_rst      : synchronous clear (independent of en)
//  en            : advance enable; 0 holds every stage
//  in_vld/in_data: element injected at the head each enabled edge
//  out_vld/out_data: element leaving stage DEPTH-1
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_rst,
  input  logic             en,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  // Each stage is {valid, data}.
  logic [DEPTH-1:0][WIDTH:0] stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0] = {in_vld, in_data};
      for (int s = 1; s < DEPTH; s++) stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           stage_q <= '0;
    else if (sync_rst) stage_q <= '0;
    else               stage_q <= stage_d;
  end

  assign out_vld  = stage_q[DEPTH-1][WIDTH];
  assign out_data = stage_q[DEPTH-1][WIDTH-1:0];

endmodule

// File: rtl/systolic_skew_streamer.sv
// Input skew stage for a LENGTH x LENGTH systolic array. One vector per
// accepted cycle; lane i is delayed by i cycles to form the wavefront. After
// the tile's last vector the block drains the wavefront and pulses tile_done.
//  CLK, ASYNC_RST, SYNC_RST : clock, async / sync active-high resets
//  EN                       : global advance enable (0 freezes all state)
//  in_valid/in_last/in_data : input vector handshake, in_ready back
//  out_data                 : skewed wavefront, lane i = out_data[i*WIDTH +: WIDTH]
//  tile_done                : one-cycle pulse when the tile has fully left
//  row_count, overflow      : vectors in current tile, sticky MAX_ROWS hit
// Optional: define LANE_VALID_EN to expose out_lane_valid[LENGTH-1:0].
module systolic_skew_streamer
  import systolic_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LENGTH   = 5,
  parameter int MAX_ROWS = 256
) (
  input  logic                         CLK,
  input  logic                         ASYNC_RST,
  input  logic                         SYNC_RST,
  input  logic                         EN,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic [WIDTH*LENGTH-1:0]      in_data,
  output logic                         in_ready,
  output logic [WIDTH*LENGTH-1:0]      out_data,
  output logic                         tile_done,
  output logic [$clog2(MAX_ROWS+1)-1:0] row_count,
`ifdef LANE_VALID_EN
  output logic [LENGTH-1:0]            out_lane_valid,
`endif
  output logic                         overflow
);

  localparam int CW    = cw_of(MAX_ROWS);
  // Drain counter only has to reach LENGTH-2.
  localparam int CNT_W = (LENGTH > 2) ? $clog2(LENGTH - 1) : 1;

  skew_state_e      state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CW-1:0]    row_count_q, row_count_d;
  logic             overflow_q, overflow_d;
  logic             tile_done_q, tile_done_d;

  logic accept, end_tile, drain_last;

  logic [LENGTH-1:0][WIDTH-1:0] lane_in, lane_out;
  logic [LENGTH-1:0]            lane_vld_out;

  assign accept     = in_valid & in_ready;
  // A full tile without in_last is closed as if in_last had been seen.
  assign end_tile   = accept & (in_last | (row_count_q == CW'(MAX_ROWS - 1)));
  assign drain_last = (state_q == DRAIN) & (drain_cnt_q == CNT_W'(LENGTH - 2));

  // Lane pipes: non-accepted cycles inject a zero bubble.
  for (genvar i = 0; i < LENGTH; i++) begin : g_lane
    assign lane_in[i] = accept ? WIDTH'(lane_get(VEC_MAX'(in_data), WIDTH, i)) : '0;

    skew_delay_line #(
      .WIDTH(WIDTH),
      .DEPTH(i + 1)
    ) u_dl (
      .clk      (CLK),
      .rst      (ASYNC_RST),
      .sync_rst (SYNC_RST),
      .en       (EN),
      .in_vld   (accept),
      .in_data  (lane_in[i]),
      .out_vld  (lane_vld_out[i]),
      .out_data (lane_out[i])
    );
  end

  // State register
  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST)     state_q <= IDLE;
    else if (SYNC_RST) state_q <= IDLE;
    else               state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (EN) begin
      unique case (state_q)
        IDLE, STREAM: begin
          if (end_tile)    state_d = (LENGTH == 1) ? IDLE : DRAIN;
          else if (accept) state_d = STREAM;
        end
        DRAIN:   if (drain_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counters, sticky overflow and done pulse
  always_comb begin
    drain_cnt_d = drain_cnt_q;
    row_count_d = row_count_q;
    overflow_d  = overflow_q;
    tile_done_d = tile_done_q;
    if (EN) begin
      tile_done_d = 1'b0;
      if (accept)
        row_count_d = (row_count_q == CW'(MAX_ROWS)) ? row_count_q : row_count_q + 1'b1;
      if (end_tile) begin
        drain_cnt_d = '0;
        if (!in_last) overflow_d = 1'b1;
        // Single-lane array: the element is already out, finish immediately.
        if (LENGTH == 1) begin
          tile_done_d = 1'b1;
          row_count_d = '0;
        end
      end
      if (state_q == DRAIN) begin
        if (drain_last) begin
          tile_done_d = 1'b1;
          row_count_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST || SYNC_RST) begin
      drain_cnt_q <= '0;
      row_count_q <= '0;
      overflow_q  <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
      row_count_q <= row_count_d;
      overflow_q  <= overflow_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Outputs
  always_comb begin
    in_ready  = EN & (state_q != DRAIN) & ~SYNC_RST;
    // A frozen cycle never shows the pulse; it reappears once EN returns.
    tile_done = tile_done_q & EN;
    row_count = row_count_q;
    overflow  = overflow_q;
    out_data  = '0;
    // Bubbles already carry zero data; gating by valid keeps the edge clean
    // even if a lane ever receives stale data.
    for (int i = 0; i < LENGTH; i++)
      out_data[i*WIDTH +: WIDTH] = lane_vld_out[i] ? lane_out[i] : '0;
  end

`ifdef LANE_VALID_EN
  assign out_lane_valid = lane_vld_out;
`endif

endmodule

// File: tb/tb_systolic_skew_streamer.sv
module tb_systolic_skew_streamer;
  localparam int W = 8, L = 4, MR = 8, CW = 4;

  logic CLK = 1'b0;
  logic ASYNC_RST, SYNC_RST, EN, in_valid, in_last;
  logic [W*L-1:0] in_data, out_data;
  logic in_ready, tile_done, overflow;
  logic [CW-1:0] row_count;
`ifdef LANE_VALID_EN
  logic [L-1:0] out_lane_valid;
`endif

  int checks = 0, errors = 0;

  // Reference model: history of injected vectors per enabled edge.
  logic [31:0] hist[$];
  bit          hv[$];
  int m_rows, m_edges, m_end;
  bit m_ovf, m_drain, m_done;

  systolic_skew_streamer #(.WIDTH(W), .LENGTH(L), .MAX_ROWS(MR)) dut (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready), .out_data(out_data), .tile_done(tile_done),
    .row_count(row_count),
`ifdef LANE_VALID_EN
    .out_lane_valid(out_lane_valid),
`endif
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  // Lane i shows the vector injected i enabled edges before the newest one.
  function automatic logic [31:0] exp_out();
    logic [31:0] r;
    int n;
    r = '0;
    n = hist.size();
    for (int i = 0; i < L; i++) if (n > i) r[i*W +: W] = hist[n-1-i][i*W +: W];
    return r;
  endfunction

  function automatic logic [L-1:0] exp_vld();
    logic [L-1:0] r;
    int n;
    r = '0;
    n = hv.size();
    for (int i = 0; i < L; i++) if (n > i) r[i] = hv[n-1-i];
    return r;
  endfunction

  function automatic bit exp_ready();
    return EN && !m_drain && !SYNC_RST;
  endfunction

  task automatic model_reset();
    hist.delete(); hv.delete();
    m_rows = 0; m_edges = 0; m_end = 0;
    m_ovf = 0; m_drain = 0; m_done = 0;
  endtask

  task automatic drive(input bit v, input bit l, input logic [31:0] d, input bit en, input bit sr);
    in_valid = v; in_last = l; in_data = d; EN = en; SYNC_RST = sr;
    #1;
  endtask

  task automatic tick();
    bit acc;
    acc = in_valid && exp_ready();
    @(posedge CLK);
    if (SYNC_RST) model_reset();
    else if (EN) begin
      m_edges++;
      m_done = 0;
      hist.push_back(acc ? in_data : 32'h0);
      hv.push_back(acc);
      if (hist.size() > L) begin void'(hist.pop_front()); void'(hv.pop_front()); end
      if (acc) begin
        if (!in_last && m_rows == MR - 1) m_ovf = 1;
        if (m_rows < MR) m_rows++;
        if (in_last || m_rows == MR) begin m_drain = 1; m_end = m_edges + L - 1; end
      end else if (m_drain && m_edges == m_end) begin
        m_drain = 0; m_done = 1; m_rows = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, $urandom, 1, 0); tick();
    drive(1, 0, $urandom, 1, 0); tick();
    checks++; if (out_data !== exp_out()) begin errors++; $display("FAIL rst_pre out_data=%h exp=%h", out_data, exp_out()); end
    drive(0, 0, $urandom, 0, 0);
    #3 ASYNC_RST = 1'b1;
    #1;
    model_reset();
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out out_data=%h exp=0", out_data); end
    checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL rst_done tile_done=%b exp=0", tile_done); end
    checks++; if (row_count !== '0) begin errors++; $display("FAIL rst_rows row_count=%0d exp=0", row_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf overflow=%b exp=0", overflow); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_en0 in_ready=%b exp=0", in_ready); end
    @(posedge CLK); #1;
    ASYNC_RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_hold in_ready=%b exp=0", in_ready); end
    drive(0, 0, 0, 1, 0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_en1 in_ready=%b exp=1", in_ready); end
  endtask

  task automatic test_skew();
    logic [7:0] r;
    int dones;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      r = 8'(c + 1);
      if (c < 4) drive(1, c == 3, {4{r}}, 1, 0);
      else       drive(0, 0, $urandom, 1, 0);
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL skew_ready c%0d in_ready=%b exp=%b", c, in_ready, exp_ready()); end
      tick();
      checks++; if (out_data !== exp_out()) begin errors++; $display("FAIL skew_out c%0d out_data=%h exp=%h", c, out_data, exp_out()); end
      checks++; if (tile_done !== (m_done && EN)) begin errors++; $display("FAIL skew_done c%0d tile_done=%b exp=%b", c, tile_done, m_done); end
      checks++; if (row_count !== CW'(m_rows)) begin errors++; $display("FAIL skew_rows c%0d row_count=%0d exp=%0d", c, row_count, m_rows); end
      if (tile_done) dones++;
      // Last row accepted at c=3, so the pulse lands three edges later.
      if (c == 6) begin
        checks++; if (tile_done !== 1'b1) begin errors++; $display("FAIL skew_done_slot tile_done=%b exp=1", tile_done); end
        checks++; if (out_data[3*W +: W] !== 8'd4) begin errors++; $display("FAIL skew_lane3 lane3=%0d exp=4", out_data[3*W +: W]); end
      end
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL skew_pulses count=%0d exp=1", dones); end
  endtask

  task automatic test_bubbles();
    bit pat_v[11] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    for (int c = 0; c < 11; c++) begin
      drive(pat_v[c], c == 5, $urandom, 1, 0);
      if (c == 2 || c == 3) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_ready c%0d in_ready=%b exp=1", c, in_ready); end
      end
      tick();
      checks++; if (out_data !== exp_out()) begin errors++; $display("FAIL bub_out c%0d out_data=%h exp=%h", c, out_data, exp_out()); end
      checks++; if (tile_done !== (m_done && EN)) begin errors++; $display("FAIL bub_done c%0d tile_done=%b exp=%b", c, tile_done, m_done); end
`ifdef LANE_VALID_EN
      checks++; if (out_lane_valid !== exp_vld()) begin errors++; $display("FAIL bub_vld c%0d vld=%b exp=%b", c, out_lane_valid, exp_vld()); end
`endif
    end
  endtask

  task automatic test_stall();
    logic [31:0] frozen;
    int since, done_at;
    since = 0; done_at = -1;
    for (int c = 0; c < 13; c++) begin
      if (c < 3) drive(1, c == 2, $urandom, 1, 0);
      else       drive(0, 0, $urandom, !(c >= 4 && c <= 6), 0);
      if (c == 4) frozen = out_data;
      tick();
      if (c >= 3) since++;
      if (c >= 4 && c <= 6) begin
        checks++; if (out_data !== frozen) begin errors++; $display("FAIL stall_frozen c%0d out_data=%h exp=%h", c, out_data, frozen); end
      end
      checks++; if (out_data !== exp_out()) begin errors++; $display("FAIL stall_out c%0d out_data=%h exp=%h", c, out_data, exp_out()); end
      checks++; if (tile_done !== (m_done && EN)) begin errors++; $display("FAIL stall_done c%0d tile_done=%b exp=%b", c, tile_done, m_done && EN); end
      if (tile_done && done_at < 0) done_at = since;
    end
    checks++; if (done_at != (L - 1) + 3) begin errors++; $display("FAIL stall_delay edges=%0d exp=%0d", done_at, (L - 1) + 3); end
  endtask

  task automatic test_overflow();
    for (int c = 0; c < 13; c++) begin
      drive(1, 0, $urandom, 1, 0);
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL ovf_ready c%0d in_ready=%b exp=%b", c, in_ready, exp_ready()); end
      tick();
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_flag c%0d overflow=%b exp=%b", c, overflow, m_ovf); end
      checks++; if (row_count !== CW'(m_rows)) begin errors++; $display("FAIL ovf_rows c%0d row_count=%0d exp=%0d", c, row_count, m_rows); end
      checks++; if (tile_done !== (m_done && EN)) begin errors++; $display("FAIL ovf_done c%0d tile_done=%b exp=%b", c, tile_done, m_done); end
      checks++; if (out_data !== exp_out()) begin errors++; $display("FAIL ovf_out c%0d out_data=%h exp=%h", c, out_data, exp_out()); end
      if (c == 7) begin
        checks++; if (overflow !== 1'b1 || row_count !== CW'(MR)) begin errors++; $display("FAIL ovf_hit overflow=%b rows=%0d exp=1/%0d", overflow, row_count, MR); end
      end
      if (c == 10) begin
        checks++; if (tile_done !== 1'b1) begin errors++; $display("FAIL ovf_done_slot tile_done=%b exp=1", tile_done); end
      end
    end
    drive(0, 0, 0, 1, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky overflow=%b exp=1", overflow); end
  endtask

  task automatic test_sync_rst();
    for (int c = 0; c < 10; c++) begin
      drive(1, 0, $urandom, 1, c == 2);
      if (c == 2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL srst_ready in_ready=%b exp=0", in_ready); end
      end
      tick();
      if (c == 2) begin
        checks++; if (out_data !== '0) begin errors++; $display("FAIL srst_out out_data=%h exp=0", out_data); end
        checks++; if (overflow !== 1'b0 || row_count !== '0) begin errors++; $display("FAIL srst_clear overflow=%b rows=%0d exp=0/0", overflow, row_count); end
      end
      checks++; if (tile_done !== (m_done && EN)) begin errors++; $display("FAIL srst_done c%0d tile_done=%b exp=%b", c, tile_done, m_done); end
      checks++; if (out_data !== exp_out()) begin errors++; $display("FAIL srst_out c%0d out_data=%h exp=%h", c, out_data, exp_out()); end
      if (c == 2) in_valid = 1'b0;
    end
    // Stop feeding and let the tile that started after the clear finish.
    for (int c = 0; c < 12; c++) begin
      drive(!m_drain, 1, $urandom, 1, 0);
      tick();
      checks++; if (tile_done !== (m_done && EN)) begin errors++; $display("FAIL srst_tail c%0d tile_done=%b exp=%b", c, tile_done, m_done); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 4) != 0, ($urandom % 5) == 0, $urandom,
            ($urandom % 6) != 0, ($urandom % 50) == 0);
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready c%0d in_ready=%b exp=%b", c, in_ready, exp_ready()); end
      tick();
      checks++; if (out_data !== exp_out()) begin errors++; $display("FAIL rnd_out c%0d out_data=%h exp=%h", c, out_data, exp_out()); end
      checks++; if (tile_done !== (m_done && EN)) begin errors++; $display("FAIL rnd_done c%0d tile_done=%b exp=%b", c, tile_done, m_done && EN); end
      checks++; if (row_count !== CW'(m_rows)) begin errors++; $display("FAIL rnd_rows c%0d row_count=%0d exp=%0d", c, row_count, m_rows); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf c%0d overflow=%b exp=%b", c, overflow, m_ovf); end
`ifdef LANE_VALID_EN
      checks++; if (out_lane_valid !== exp_vld()) begin errors++; $display("FAIL rnd_vld c%0d vld=%b exp=%b", c, out_lane_valid, exp_vld()); end
`endif
    end
  endtask

  initial begin
    ASYNC_RST = 1'b1; SYNC_RST = 1'b0; EN = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 ASYNC_RST = 1'b0;
    test_reset();
    test_skew();
    test_bubbles();
    test_stall();
    test_overflow();
    test_sync_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
